bsg_dmc_xilinx_ui_to_trace_adapter: RTL and testbench



---
 rtl/bsg_dmc_xilinx_ui_to_trace_adapter_if.sv | 56 +++++
 rtl/bsg_dmc_xilinx_ui_to_trace_adapter.sv | 212 +++++++++++++++++++++
 tb/tb_bsg_dmc_xilinx_ui_to_trace_adapter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bsg_dmc_xilinx_ui_to_trace_adapter_if.sv
// UI command/write/read bundle plus the trace stream and returned read beats.
// Pure wiring, no latency.
// Backpressure: app_rdy/app_wdf_rdy/trace_ready; read_data_v has none.
interface bsg_dmc_xilinx_ui_to_trace_adapter_if #(
    parameter int data_width_p = 32,
    parameter int addr_width_p = 28,
    parameter int cmd_width_p  = 3
);
    localparam int mask_width_lp  = data_width_p / 8;
    localparam int trace_width_lp = data_width_p + mask_width_lp + 4;

    logic [addr_width_p-1:0]   app_addr_i;
    logic [cmd_width_p-1:0]    app_cmd_i;
    logic                      app_en_i;
    logic                      app_rdy_o;
    logic                      app_wdf_wren_i;
    logic [data_width_p-1:0]   app_wdf_data_i;
    logic [mask_width_lp-1:0]  app_wdf_mask_i;
    logic                      app_wdf_end_i;
    logic                      app_wdf_rdy_o;
    logic                      app_rd_data_valid_o;
    logic [data_width_p-1:0]   app_rd_data_o;
    logic                      app_rd_data_end_o;
    logic [trace_width_lp-1:0] trace_data_o;
    logic                      trace_data_v_o;
    logic                      trace_ready_i;
    logic [data_width_p-1:0]   read_data_i;
    logic                      read_data_v_i;
    logic                      error_o;

    // Adapter side
    modport slave (
        input  app_addr_i, app_cmd_i, app_en_i,
        output app_rdy_o,
        input  app_wdf_wren_i, app_wdf_data_i, app_wdf_mask_i, app_wdf_end_i,
        output app_wdf_rdy_o,
        output app_rd_data_valid_o, app_rd_data_o, app_rd_data_end_o,
        output trace_data_o, trace_data_v_o,
        input  trace_ready_i,
        input  read_data_i, read_data_v_i,
        output error_o
    );

    // UI master / trace consumer side
    modport master (
        output app_addr_i, app_cmd_i, app_en_i,
        input  app_rdy_o,
        output app_wdf_wren_i, app_wdf_data_i, app_wdf_mask_i, app_wdf_end_i,
        input  app_wdf_rdy_o,
        input  app_rd_data_valid_o, app_rd_data_o, app_rd_data_end_o,
        input  trace_data_o, trace_data_v_o,
        output trace_ready_i,
        output read_data_i, read_data_v_i,
        input  error_o
    );
endinterface

// File: rtl/bsg_dmc_xilinx_ui_to_trace_adapter.sv
// Serialises UI commands + write data into DMC trace packets; returns read beats as UI read data.
// Latency: cmd accepted in N -> cmd packet in N+1, first data packet >= N+2; read beats +1 cycle.
// Backpressure: trace_ready_i stalls packets; app_rdy_o/app_wdf_rdy_o drop on busy/read-limit/FIFO full.
// Optional: define BSG_DMC_UI_TO_TRACE_ERR_CHECK_EN to build sticky protocol error checking on error_o.
module bsg_dmc_xilinx_ui_to_trace_adapter #(
    parameter int data_width_p  = 32,
    parameter int addr_width_p  = 28,
    parameter int cmd_width_p   = 3,
    parameter int burst_width_p = 2,
    parameter int wdf_els_p     = 4,
    parameter int max_reads_p   = 4
) (
    input logic core_clk_i,
    input logic core_reset_i,
    bsg_dmc_xilinx_ui_to_trace_adapter_if.slave ui
);
    localparam int mask_width_lp  = data_width_p / 8;
    localparam int trace_width_lp = data_width_p + mask_width_lp + 4;
    localparam int fifo_width_lp  = data_width_p + mask_width_lp;
    localparam int ptr_width_lp   = (wdf_els_p > 1) ? $clog2(wdf_els_p) : 1;
    localparam int cnt_width_lp   = $clog2(wdf_els_p + 1);
    localparam int beat_width_lp  = $clog2(burst_width_p);
    localparam int rd_width_lp    = $clog2(max_reads_p + 1);

    localparam logic [cmd_width_p-1:0] cmd_wr_lp = cmd_width_p'(0);
    localparam logic [cmd_width_p-1:0] cmd_rd_lp = cmd_width_p'(1);
    localparam logic [cmd_width_p-1:0] cmd_wp_lp = cmd_width_p'(3);
    localparam logic [cmd_width_p-1:0] cmd_rp_lp = cmd_width_p'(5);
    localparam logic [beat_width_lp-1:0] last_beat_lp = beat_width_lp'(burst_width_p - 1);

    typedef enum logic [1:0] {e_idle, e_cmd, e_wdata} state_e;

    state_e                    state_q, state_d;
    logic [cmd_width_p-1:0]    cmd_q, cmd_d;
    logic [addr_width_p-1:0]   addr_q, addr_d;
    logic [beat_width_lp-1:0]  beat_cnt_q, beat_cnt_d;
    logic [rd_width_lp-1:0]    outstanding_q, outstanding_d;
    logic [beat_width_lp-1:0]  rd_beat_cnt_q;
    logic                      rd_v_q, rd_end_q;
    logic [data_width_p-1:0]   rd_data_q;

    logic [fifo_width_lp-1:0]  fifo_mem_q [wdf_els_p];
    logic [ptr_width_lp-1:0]   wr_ptr_q, rd_ptr_q;
    logic [cnt_width_lp-1:0]   fifo_cnt_q;
    logic                      fifo_full, fifo_empty, wdf_push, wdf_pop;

    logic                      trace_v_raw, app_rdy_raw, rd_inc, rd_dec;
    logic [trace_width_lp-1:0] trace_pkt;
    logic                      cmd_is_write, cmd_is_read;

    assign fifo_full  = (fifo_cnt_q == cnt_width_lp'(wdf_els_p));
    assign fifo_empty = (fifo_cnt_q == '0);
    // Reset also blocks pushes so a reset cycle never captures write data.
    assign wdf_push   = ui.app_wdf_wren_i & ~fifo_full & ~core_reset_i;
    assign wdf_pop    = (state_q == e_wdata) & ~fifo_empty & ui.trace_ready_i;

    assign cmd_is_write = (cmd_q == cmd_wr_lp) | (cmd_q == cmd_wp_lp);
    assign cmd_is_read  = (cmd_q == cmd_rd_lp) | (cmd_q == cmd_rp_lp);

    // Next state, packet formation and command acceptance
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        beat_cnt_d  = beat_cnt_q;
        trace_v_raw = 1'b0;
        trace_pkt   = '0;
        app_rdy_raw = 1'b0;
        rd_inc      = 1'b0;
        unique case (state_q)
            e_idle: begin
                app_rdy_raw = (outstanding_q < rd_width_lp'(max_reads_p));
                if (ui.app_en_i && app_rdy_raw) begin
                    cmd_d   = ui.app_cmd_i;
                    addr_d  = ui.app_addr_i;
                    state_d = e_cmd;
                end
            end
            e_cmd: begin
                trace_v_raw = 1'b1;
                trace_pkt[trace_width_lp-1] = 1'b1;
                trace_pkt[cmd_width_p+addr_width_p-1 -: cmd_width_p] = cmd_q;
                trace_pkt[addr_width_p-1:0] = addr_q;
                if (ui.trace_ready_i) begin
                    if (cmd_is_write) begin
                        state_d    = e_wdata;
                        beat_cnt_d = '0;
                    end else begin
                        state_d = e_idle;
                        rd_inc  = cmd_is_read;
                    end
                end
            end
            e_wdata: begin
                trace_v_raw = ~fifo_empty;
                trace_pkt[fifo_width_lp-1:0] = fifo_mem_q[rd_ptr_q];
                if (wdf_pop) begin
                    beat_cnt_d = beat_cnt_q + beat_width_lp'(1);
                    if (beat_cnt_q == last_beat_lp) state_d = e_idle;
                end
            end
            default: state_d = e_idle;
        endcase
    end

    // FSM and latched command registers
    always_ff @(posedge core_clk_i) begin
        if (core_reset_i) begin
            state_q    <= e_idle;
            cmd_q      <= '0;
            addr_q     <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Write-data FIFO storage, no reset needed on the payload
    always_ff @(posedge core_clk_i) begin
        if (wdf_push) fifo_mem_q[wr_ptr_q] <= {ui.app_wdf_data_i, ui.app_wdf_mask_i};
    end

    // Write-data FIFO pointers and occupancy
    always_ff @(posedge core_clk_i) begin
        if (core_reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (wdf_push)
                wr_ptr_q <= (wr_ptr_q == ptr_width_lp'(wdf_els_p - 1)) ? '0 : wr_ptr_q + ptr_width_lp'(1);
            if (wdf_pop)
                rd_ptr_q <= (rd_ptr_q == ptr_width_lp'(wdf_els_p - 1)) ? '0 : rd_ptr_q + ptr_width_lp'(1);
            case ({wdf_push, wdf_pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + cnt_width_lp'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - cnt_width_lp'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // Read credit: +1 when a read command leaves, -1 on the last returned beat
    assign rd_dec = ui.read_data_v_i & (rd_beat_cnt_q == last_beat_lp) & (outstanding_q != '0);
    always_comb begin
        outstanding_d = outstanding_q;
        if (rd_inc && !rd_dec)      outstanding_d = outstanding_q + rd_width_lp'(1);
        else if (!rd_inc && rd_dec) outstanding_d = outstanding_q - rd_width_lp'(1);
    end

    // Read return path: one register stage, beat counter marks burst end
    always_ff @(posedge core_clk_i) begin
        if (core_reset_i) begin
            rd_v_q        <= 1'b0;
            rd_end_q      <= 1'b0;
            rd_data_q     <= '0;
            rd_beat_cnt_q <= '0;
            outstanding_q <= '0;
        end else begin
            rd_v_q        <= ui.read_data_v_i;
            rd_end_q      <= ui.read_data_v_i & (rd_beat_cnt_q == last_beat_lp);
            rd_data_q     <= ui.read_data_i;
            outstanding_q <= outstanding_d;
            if (ui.read_data_v_i) rd_beat_cnt_q <= rd_beat_cnt_q + beat_width_lp'(1);
        end
    end

    // Every output is forced low while reset is held.
    assign ui.app_rdy_o           = app_rdy_raw & ~core_reset_i;
    assign ui.app_wdf_rdy_o       = ~fifo_full & ~core_reset_i;
    assign ui.trace_data_v_o      = trace_v_raw & ~core_reset_i;
    assign ui.trace_data_o        = (trace_v_raw & ~core_reset_i) ? trace_pkt : '0;
    assign ui.app_rd_data_valid_o = rd_v_q & ~core_reset_i;
    assign ui.app_rd_data_end_o   = rd_end_q & ~core_reset_i;
    assign ui.app_rd_data_o       = core_reset_i ? '0 : rd_data_q;

`ifdef BSG_DMC_UI_TO_TRACE_ERR_CHECK_EN
    logic                     err_q, err_d;
    logic [beat_width_lp-1:0] wdf_push_cnt_q;
    logic                     cmd_in_legal;

    assign cmd_in_legal = (ui.app_cmd_i == cmd_wr_lp) | (ui.app_cmd_i == cmd_wp_lp)
                        | (ui.app_cmd_i == cmd_rd_lp) | (ui.app_cmd_i == cmd_rp_lp);

    // Sticky error: unsolicited read data, misplaced wdf_end, unknown command
    always_comb begin
        err_d = err_q;
        if (ui.read_data_v_i && (outstanding_q == '0))                   err_d = 1'b1;
        if (wdf_push && ui.app_wdf_end_i && (wdf_push_cnt_q != last_beat_lp)) err_d = 1'b1;
        if (ui.app_en_i && !cmd_in_legal)                                 err_d = 1'b1;
    end

    // Error flag and write-beat position within the burst
    always_ff @(posedge core_clk_i) begin
        if (core_reset_i) begin
            err_q          <= 1'b0;
            wdf_push_cnt_q <= '0;
        end else begin
            err_q <= err_d;
            if (wdf_push) wdf_push_cnt_q <= wdf_push_cnt_q + beat_width_lp'(1);
        end
    end

    assign ui.error_o = err_q & ~core_reset_i;
`else
    logic unused_wdf_end;
    assign unused_wdf_end = ui.app_wdf_end_i;
    assign ui.error_o     = 1'b0;
`endif
endmodule

// File: tb/tb_bsg_dmc_xilinx_ui_to_trace_adapter.sv
module tb_bsg_dmc_xilinx_ui_to_trace_adapter;
    localparam int DW = 32, AW = 28, CW = 3, BW = 2, FE = 4, MR = 4;
    localparam logic [2:0] C_WR = 3'd0, C_RD = 3'd1, C_WP = 3'd3, C_RP = 3'd5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bsg_dmc_xilinx_ui_to_trace_adapter_if #(.data_width_p(DW), .addr_width_p(AW), .cmd_width_p(CW)) ui ();

    bsg_dmc_xilinx_ui_to_trace_adapter #(
        .data_width_p(DW), .addr_width_p(AW), .cmd_width_p(CW),
        .burst_width_p(BW), .wdf_els_p(FE), .max_reads_p(MR)
    ) dut (
        .core_clk_i(clk),
        .core_reset_i(rst),
        .ui(ui)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // exp_q: packets still owed on the trace port; bit39=1 is a full command
    // packet, bit39=0 is a slot for "next beat of the write-data stream".
    logic [39:0] exp_q[$];
    logic [39:0] wdf_q[$];   // write beats accepted but not yet sent, as data packets
    logic [39:0] log_q[$];   // packets actually handed off by the DUT
    int          outst;
    int          rd_cnt;
    int          push_n;
    bit          m_rd_v, m_rd_end, m_err;
    logic [31:0] m_rd_dat;

    function automatic bit is_wr(input logic [2:0] c); return (c == C_WR) || (c == C_WP); endfunction
    function automatic bit is_rd(input logic [2:0] c); return (c == C_RD) || (c == C_RP); endfunction

    // Compare outputs against the model, then advance the model by the coming edge
    always @(negedge clk) begin
        logic [39:0] head, ed, pkt;
        bit has_head, ev, erdy, pushed, dec;
        if (rst) begin
            chk("rst_trace_v",  ui.trace_data_v_o, 0);
            chk("rst_trace_d",  ui.trace_data_o, 0);
            chk("rst_app_rdy",  ui.app_rdy_o, 0);
            chk("rst_wdf_rdy",  ui.app_wdf_rdy_o, 0);
            chk("rst_rd_v",     ui.app_rd_data_valid_o, 0);
            chk("rst_rd_d",     ui.app_rd_data_o, 0);
            chk("rst_rd_end",   ui.app_rd_data_end_o, 0);
            chk("rst_err",      ui.error_o, 0);
            exp_q.delete(); wdf_q.delete();
            outst = 0; rd_cnt = 0; push_n = 0;
            m_rd_v = 0; m_rd_end = 0; m_err = 0; m_rd_dat = 0;
        end else begin
            has_head = exp_q.size() > 0;
            head     = has_head ? exp_q[0] : 40'h0;
            ev       = has_head && (head[39] || wdf_q.size() > 0);
            ed       = !ev ? 40'h0 : (head[39] ? head : wdf_q[0]);
            erdy     = !has_head && (outst < MR);
            chk("trace_v",   ui.trace_data_v_o, ev);
            chk("trace_d",   ui.trace_data_o, ed);
            chk("app_rdy",   ui.app_rdy_o, erdy);
            chk("wdf_rdy",   ui.app_wdf_rdy_o, wdf_q.size() < FE);
            chk("rd_v",      ui.app_rd_data_valid_o, m_rd_v);
            if (m_rd_v) chk("rd_d", ui.app_rd_data_o, m_rd_dat);
            chk("rd_end",    ui.app_rd_data_end_o, m_rd_end);
            chk("error",     ui.error_o, m_err);

            if (ui.trace_data_v_o && ui.trace_ready_i) log_q.push_back(ui.trace_data_o);

            pushed = ui.app_wdf_wren_i && (wdf_q.size() < FE);
            dec    = ui.read_data_v_i && (rd_cnt == BW - 1) && (outst > 0);
`ifdef BSG_DMC_UI_TO_TRACE_ERR_CHECK_EN
            if (ui.read_data_v_i && outst == 0) m_err = 1;
            if (pushed && ui.app_wdf_end_i && (push_n % BW) != BW - 1) m_err = 1;
            if (ui.app_en_i && !is_wr(ui.app_cmd_i) && !is_rd(ui.app_cmd_i)) m_err = 1;
`endif
            if (ev && ui.trace_ready_i) begin
                void'(exp_q.pop_front());
                if (head[39]) begin
                    if (is_rd(head[30:28])) outst++;
                end else begin
                    void'(wdf_q.pop_front());
                end
            end
            if (pushed) begin
                wdf_q.push_back({4'b0, ui.app_wdf_data_i, ui.app_wdf_mask_i});
                push_n++;
            end
            if (ui.app_en_i && erdy) begin
                pkt = 40'h0;
                pkt[39] = 1'b1;
                pkt[30:28] = ui.app_cmd_i;
                pkt[27:0]  = ui.app_addr_i;
                exp_q.push_back(pkt);
                if (is_wr(ui.app_cmd_i)) for (int b = 0; b < BW; b++) exp_q.push_back(40'h0);
            end
            m_rd_v   = ui.read_data_v_i;
            m_rd_dat = ui.read_data_i;
            m_rd_end = ui.read_data_v_i && (rd_cnt == BW - 1);
            if (dec) outst--;
            if (ui.read_data_v_i) rd_cnt = (rd_cnt + 1) % BW;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(); @(posedge clk); #1; endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (exp_q.size() != 0 && k < 50) begin cyc(); k++; end
        chk(nm, exp_q.size(), 0);
    endtask

    task automatic send_cmd(input logic [2:0] c, input logic [27:0] a);
        ui.app_en_i = 1; ui.app_cmd_i = c; ui.app_addr_i = a;
        cyc();
        ui.app_en_i = 0;
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] m, input logic e);
        ui.app_wdf_wren_i = 1; ui.app_wdf_data_i = d; ui.app_wdf_mask_i = m; ui.app_wdf_end_i = e;
        cyc();
        ui.app_wdf_wren_i = 0; ui.app_wdf_end_i = 0;
    endtask

    task automatic rd_ret(input logic [31:0] d);
        ui.read_data_v_i = 1; ui.read_data_i = d;
        cyc();
        ui.read_data_v_i = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: sim time %0t exceeded bound", $time);
        $fatal(1);
    end

    initial begin
        ui.app_addr_i = 0; ui.app_cmd_i = 0; ui.app_en_i = 0;
        ui.app_wdf_wren_i = 0; ui.app_wdf_data_i = 0; ui.app_wdf_mask_i = 0; ui.app_wdf_end_i = 0;
        ui.trace_ready_i = 1; ui.read_data_i = 0; ui.read_data_v_i = 0;

        // Reset state
        rst = 1;
        repeat (3) cyc();
        chk("lit_rst_app_rdy", ui.app_rdy_o, 0);
        chk("lit_rst_wdf_rdy", ui.app_wdf_rdy_o, 0);
        rst = 0;
        cyc();
        chk("lit_idle_app_rdy", ui.app_rdy_o, 1);
        chk("lit_idle_wdf_rdy", ui.app_wdf_rdy_o, 1);

        // Write: data ahead of the command
        log_q.delete();
        push(32'hA5A5A5A5, 4'h0, 0);
        push(32'h5A5A5A5A, 4'hF, 1);
        send_cmd(C_WR, 28'h100);
        wait_idle("wr_idle");
        chk("wr_npkts", log_q.size(), 3);
        if (log_q.size() == 3) begin
            chk("wr_cmd_pkt", log_q[0], 40'h80_0000_0100);
            chk("wr_dat0",    log_q[1], 40'h0A_5A5A_5A50);
            chk("wr_dat1",    log_q[2], 40'h05_A5A5_A5AF);
        end
        cyc();
        chk("wr_back_idle", ui.app_rdy_o, 1);

        // Read
        log_q.delete();
        send_cmd(C_RD, 28'h40);
        wait_idle("rd_idle");
        chk("rd_cmd_pkt", log_q.size() > 0 ? log_q[0] : 40'h0, 40'h80_1000_0040);
        ui.read_data_v_i = 1; ui.read_data_i = 32'h11;
        cyc();
        chk("lit_rd0_v", ui.app_rd_data_valid_o, 1);
        chk("lit_rd0_d", ui.app_rd_data_o, 32'h11);
        chk("lit_rd0_end", ui.app_rd_data_end_o, 0);
        ui.read_data_i = 32'h22;
        cyc();
        ui.read_data_v_i = 0;
        chk("lit_rd1_d", ui.app_rd_data_o, 32'h22);
        chk("lit_rd1_end", ui.app_rd_data_end_o, 1);
        cyc();
        chk("lit_rd_done_v", ui.app_rd_data_valid_o, 0);

        // Backpressure during CMD, FIFO fills meanwhile
        log_q.delete();
        ui.trace_ready_i = 0;
        send_cmd(C_WR, 28'h200);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                ui.app_wdf_wren_i = 1; ui.app_wdf_data_i = 32'h1000 + i;
                ui.app_wdf_mask_i = 4'(i); ui.app_wdf_end_i = (i % 2 == 1);
            end else begin
                ui.app_wdf_wren_i = 0; ui.app_wdf_end_i = 0;
            end
            chk("bp_hold_v", ui.trace_data_v_o, 1);
            chk("bp_hold_d", ui.trace_data_o, 40'h80_0000_0200);
            chk("bp_app_rdy", ui.app_rdy_o, 0);
            cyc();
        end
        chk("bp_wdf_full", ui.app_wdf_rdy_o, 0);
        ui.trace_ready_i = 1;
        wait_idle("bp_idle");
        chk("bp_wdf_rdy_again", ui.app_wdf_rdy_o, 1);
        send_cmd(C_WP, 28'h300);
        wait_idle("wp_idle");
        chk("bp_npkts", log_q.size(), 6);
        if (log_q.size() == 6) begin
            chk("bp_dat0", log_q[1], 40'h00_0001_0000);
            chk("bp_dat1", log_q[2], 40'h00_0001_0011);
            chk("wp_cmd",  log_q[3], 40'h80_3000_0300);
            chk("wp_dat1", log_q[5], 40'h00_0001_0033);
        end

        // Read limit
        for (int i = 0; i < MR; i++) begin
            send_cmd(C_RD, 28'h80 + 28'(i));
            wait_idle("lim_idle");
        end
        cyc();
        chk("lim_app_rdy_low", ui.app_rdy_o, 0);
        ui.read_data_v_i = 1; ui.read_data_i = 32'hA0;
        cyc();
        ui.read_data_i = 32'hA1;
        cyc();
        ui.read_data_v_i = 0;
        chk("lim_app_rdy_back", ui.app_rdy_o, 1);
        for (int i = 0; i < 2 * (MR - 1); i++) rd_ret(32'hB0 + 32'(i));
        cyc();

        // Reset in the middle of a write burst
        log_q.delete();
        push(32'hDEADBEEF, 4'h0, 0);
        send_cmd(C_WR, 28'h400);
        begin
            int k = 0;
            while (log_q.size() < 2 && k < 30) begin cyc(); k++; end
            chk("mid_pkts_before_rst", log_q.size(), 2);
        end
        rst = 1;
        ui.app_wdf_wren_i = 1; ui.app_wdf_data_i = 32'h55; ui.app_wdf_mask_i = 0;
        cyc();
        chk("lit_mid_rst_v", ui.trace_data_v_o, 0);
        chk("lit_mid_rst_wdf", ui.app_wdf_rdy_o, 0);
        rst = 0;
        ui.app_wdf_wren_i = 0;
        cyc();
        chk("lit_post_rst_wdf", ui.app_wdf_rdy_o, 1);
        repeat (5) cyc();
        chk("lit_post_rst_nopkts", log_q.size(), 2);
        chk("lit_post_rst_v", ui.trace_data_v_o, 0);

        // Unsolicited read data
        rd_ret(32'h77);
        repeat (3) cyc();
`ifdef BSG_DMC_UI_TO_TRACE_ERR_CHECK_EN
        chk("lit_err_sticky", ui.error_o, 1);
`else
        chk("lit_err_tied", ui.error_o, 0);
`endif
        rst = 1;
        cyc();
        rst = 0;
        cyc();
        chk("lit_err_cleared", ui.error_o, 0);

        repeat (3) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
